main_fsm: RTL and testbench

Moore control state machine for the multi-cycle RV32I core. It sits directly upstream of the ALU decoder and sequences every instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and mux selects, including the 2-bit `ALUOp` that the ALU decoder expands into `ALUControl`. Supported opcodes: lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/main_fsm_pkg.sv | 56 +++++
 rtl/main_fsm_if.sv | 28 ++
 rtl/main_fsm_outdec.sv | 78 +++++++
 rtl/main_fsm.sv | 70 +++++++
 tb/tb_main_fsm.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/main_fsm_pkg.sv
// Shared control constants for the multi-cycle RV32I core: FSM states, opcodes,
// datapath select encodings and the bundled control-word type.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE_R = 4'd6,
    S_EXECUTE_I = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // The ALU decoder imports these same ALUOp values.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_if.sv
// Control bus between the main FSM (master) and the datapath (slave): opcode in,
// enables and mux selects out.
interface main_fsm_if;
  logic [6:0] Op;
  logic       PCUpdate;
  logic       Branch;
  logic       RegWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [3:0] StateOut;

  modport master (
    input  Op,
    output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, StateOut
  );

  modport slave (
    output Op,
    input  PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, StateOut
  );
endinterface

// File: rtl/main_fsm_outdec.sv
// Moore output decoder: maps the current state to the full datapath control word.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.pc_update  = 1'b1;
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADR: begin
        ctrl_o.alu_src_a = SRCA_REG;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.adr_src    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
      end
      S_EXECUTE_R: begin
        ctrl_o.alu_src_a = SRCA_REG;
        ctrl_o.alu_src_b = SRCB_WDATA;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTE_I: begin
        ctrl_o.alu_src_a = SRCA_REG;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a  = SRCA_REG;
        ctrl_o.alu_src_b  = SRCB_WDATA;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.branch     = 1'b1;
      end
      S_JAL: begin
        ctrl_o.alu_src_a  = SRCA_OLDPC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_update  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: state register and next-state
// logic; outputs come from the Moore decoder and depend on state only.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  main_fsm_if.master  bus
);

  state_e             state_q, state_d;
  ctrl_t              ctrl;
  logic [STATE_W-1:0] state_raw;

  // Reset is asynchronous so a mid-instruction abort takes effect before the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (bus.Op == OP_LW || bus.Op == OP_SW) state_d = S_MEM_ADR;
        else if (bus.Op == OP_R)                state_d = S_EXECUTE_R;
        else if (bus.Op == OP_I)                state_d = S_EXECUTE_I;
        else if (bus.Op == OP_BEQ)              state_d = S_BEQ;
        else if (bus.Op == OP_JAL)              state_d = S_JAL;
        else                                    state_d = S_FETCH;
      end
      S_MEM_ADR:   state_d = (bus.Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXECUTE_R: state_d = S_ALU_WB;
      S_EXECUTE_I: state_d = S_ALU_WB;
      S_JAL:       state_d = S_ALU_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_FETCH;
      S_ALU_WB:    state_d = S_FETCH;
      S_BEQ:       state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign state_raw     = state_q;
  assign bus.StateOut  = state_raw;
  assign bus.PCUpdate  = ctrl.pc_update;
  assign bus.Branch    = ctrl.branch;
  assign bus.RegWrite  = ctrl.reg_write;
  assign bus.MemWrite  = ctrl.mem_write;
  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.ResultSrc = ctrl.result_src;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: expected state sequences are queued when an
// opcode is driven and popped one per cycle against StateOut and the control word.
module tb_main_fsm;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   exp_q[$];

  main_fsm_if bus ();

  main_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control word packing: {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,
  // ResultSrc,ALUSrcA,ALUSrcB,ALUOp}.
  function automatic logic [13:0] actual_ctrl();
    return {bus.PCUpdate, bus.Branch, bus.RegWrite, bus.MemWrite, bus.IRWrite,
            bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp};
  endfunction

  function automatic logic [13:0] exp_ctrl(input int st);
    case (st)
      0:  return {6'b100010, 2'b10, 2'b00, 2'b10, 2'b00};
      1:  return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
      2:  return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
      3:  return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
      4:  return {6'b001000, 2'b01, 2'b00, 2'b00, 2'b00};
      5:  return {6'b000101, 2'b00, 2'b00, 2'b00, 2'b00};
      6:  return {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
      7:  return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
      8:  return {6'b001000, 2'b00, 2'b00, 2'b00, 2'b00};
      9:  return {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01};
      10: return {6'b100000, 2'b00, 2'b01, 2'b10, 2'b00};
      default: return 14'd0;
    endcase
  endfunction

  task automatic push_seq(input logic [6:0] op);
    exp_q.push_back(0);
    exp_q.push_back(1);
    case (op)
      7'b0000011: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
      7'b0100011: begin exp_q.push_back(2); exp_q.push_back(5); end
      7'b0110011: begin exp_q.push_back(6); exp_q.push_back(8); end
      7'b0010011: begin exp_q.push_back(7); exp_q.push_back(8); end
      7'b1100011: exp_q.push_back(9);
      7'b1101111: begin exp_q.push_back(10); exp_q.push_back(8); end
      default: ;
    endcase
  endtask

  // Entered at a negedge with the DUT in Fetch; leaves at the negedge of the
  // following Fetch.
  task automatic score_instr(input logic [6:0] op, input string name);
    int st;
    bus.Op = op;
    push_seq(op);
    while (exp_q.size() > 0) begin
      st = exp_q.pop_front();
      tests_run++;
      if (bus.StateOut !== 4'(st)) begin
        tests_failed++;
        $display("FAIL %s state: got %0d expected %0d", name, bus.StateOut, st);
      end
      tests_run++;
      if (actual_ctrl() !== exp_ctrl(st)) begin
        tests_failed++;
        $display("FAIL %s ctrl in state %0d: got %b expected %b", name, st,
                 actual_ctrl(), exp_ctrl(st));
      end
      @(negedge clk);
    end
    tests_run++;
    if (bus.StateOut !== 4'd0) begin
      tests_failed++;
      $display("FAIL %s return to fetch: got %0d expected 0", name, bus.StateOut);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bus.Op = 7'b0000000;
    #3;
    tests_run++;
    if (bus.StateOut !== 4'd0 || actual_ctrl() !== exp_ctrl(0)) begin
      tests_failed++;
      $display("FAIL reset_initial: got state %0d ctrl %b expected state 0 ctrl %b",
               bus.StateOut, actual_ctrl(), exp_ctrl(0));
    end
    @(negedge clk);
    reset = 1'b0;
    // Walk a lw into MemRead, then abort it asynchronously mid-cycle.
    bus.Op = 7'b0000011;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.StateOut !== 4'd3) begin
      tests_failed++;
      $display("FAIL reset_setup: got state %0d expected 3", bus.StateOut);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (bus.StateOut !== 4'd0 || bus.IRWrite !== 1'b1 || bus.PCUpdate !== 1'b1 ||
        bus.RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got state %0d IRWrite %b PCUpdate %b RegWrite %b expected 0 1 1 0",
               bus.StateOut, bus.IRWrite, bus.PCUpdate, bus.RegWrite);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.StateOut !== 4'd0 || actual_ctrl() !== exp_ctrl(0)) begin
      tests_failed++;
      $display("FAIL reset_hold: got state %0d ctrl %b expected state 0 ctrl %b",
               bus.StateOut, actual_ctrl(), exp_ctrl(0));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lw();      score_instr(7'b0000011, "lw");      endtask
  task automatic test_sw();      score_instr(7'b0100011, "sw");      endtask
  task automatic test_r_then_i();
    score_instr(7'b0110011, "rtype");
    score_instr(7'b0010011, "itype");
  endtask
  task automatic test_beq_then_jal();
    score_instr(7'b1100011, "beq");
    score_instr(7'b1101111, "jal");
  endtask
  task automatic test_illegal();
    score_instr(7'b0000000, "illegal_zero");
    score_instr(7'b1111111, "illegal_ones");
  endtask

  task automatic test_latency();
    logic [6:0] ops [7];
    int         lat [7];
    int         cnt;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011, 7'b0001011};
    lat = '{5, 4, 4, 4, 4, 3, 2};
    for (int i = 0; i < 7; i++) begin
      bus.Op = ops[i];
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (bus.StateOut !== 4'd0 && cnt < 20);
      tests_run++;
      if (cnt != lat[i]) begin
        tests_failed++;
        $display("FAIL latency op=%b: got %0d cycles expected %0d", ops[i], cnt, lat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] pool [8];
    pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
             7'b1100011, 7'b1101111, 7'b0000000, 7'b0110111};
    for (int i = 0; i < 24; i++)
      score_instr(pool[$urandom_range(0, 7)], "b2b");
  endtask

  initial begin
    clk          = 1'b0;
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_lw();
    test_sw();
    test_r_then_i();
    test_beq_then_jal();
    test_illegal();
    test_latency();
    test_back_to_back();
    test_reset();
    test_lw();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
